ddr3_app_arbiter: RTL and testbench
===================================

Name: ddr3_app_arbiter

Overview:
- Two-requester arbiter that shares the single Gowin DDR3 controller application interface (cmd/addr/burst, write-data, read-data channels) between port 0 and port 1, e.g. CPU bus bridge and DMA/video engine.
- Sits between the requesters and the DDR3 memory interface top, in the controller's divided user clock domain.
- Grants whole transactions round-robin, sequences write-data beats for the granted port, and steers in-order read returns back to the issuing port through a tag FIFO.

Parameters:
ADDR_W, 27, app address width
DATA_W, 128, app data width
MASK_W, 16, write mask width (DATA_W/8)
BURST_W, 6, app_burst_number width; beats per command = burst_number+1
TAG_DEPTH, 8, max outstanding read commands (power of 2)

Ports:
clk  in  1  controller user clock (clk_out of DDR3 interface); sole clock
rstn  in  1  synchronous active-low reset
init_calib_complete  in  1  controller ready; no grants while low
pN_cmd_en  in  1  (N=0,1) request; held with cmd/addr/burst until pN_cmd_rdy
pN_cmd  in  3  3'b000 write, 3'b001 read
pN_addr  in  ADDR_W  command address
pN_burst_number  in  BURST_W  beats minus 1
pN_cmd_rdy  out  1  one-cycle pulse: command accepted by controller
pN_wdata_en  in  1  write beat valid
pN_wdata  in  DATA_W  write data
pN_wdata_mask  in  MASK_W  write mask
pN_wdata_rdy  out  1  write beat accepted when pN_wdata_en & pN_wdata_rdy
pN_rdata  out  DATA_W  read data (app_rdata, broadcast)
pN_rdata_valid  out  1  read beat for port N
pN_rdata_end  out  1  last beat of a port N read command
app_cmd_en, app_cmd, app_addr, app_burst_number  out  1/3/ADDR_W/BURST_W  to controller
app_cmd_rdy  in  1  controller command ready
app_wdata_en, app_wdata_end, app_wdata, app_wdata_mask  out  1/1/DATA_W/MASK_W  to controller
app_wdata_rdy  in  1
app_rdata_valid, app_rdata_end, app_rdata  in  1/1/DATA_W  from controller
err_orphan_rdata  out  1  sticky: read data arrived with tag FIFO empty, or illegal cmd seen

Behaviour:
- Reset (rstn low at clk edge): state=IDLE, rr pointer=0 (port 0 favoured), tag FIFO emptied, beat counter=0, err_orphan_rdata=0; all app_* outputs 0, pN_cmd_rdy/pN_wdata_rdy/pN_rdata_valid/pN_rdata_end=0. Reset mid-burst abandons the transaction; no completion.
- FSM IDLE: if init_calib_complete and any eligible pN_cmd_en, grant; both requesting -> port != rr pointer... rule: grant port rr, rr flips to other port after grant. Single requester is granted regardless of rr. A read request is eligible only if tag FIFO not full; an ineligible read never blocks the other port. Grant latches cmd/addr/burst into registers; next state CMD.
- CMD: app_cmd_en=1 with latched fields. On app_cmd_rdy=1: pulse pN_cmd_rdy for the granted port that cycle; read -> push tag N, go IDLE; write -> beat counter=0, go WDATA; other cmd -> forward, set err, go IDLE.
- WDATA: app_wdata_en/app_wdata/app_wdata_mask = granted port's inputs; pN_wdata_rdy = app_wdata_rdy for granted port, 0 for the other. Beat counted on wdata_en & app_wdata_rdy. app_wdata_end=1 on the beat where counter==latched burst_number; that beat returns to IDLE. Minimum turnaround: one IDLE cycle between transactions.
- Calib low: no new grants; a transaction in CMD/WDATA completes.
- Read return (independent of FSM): head tag H selects port; pH_rdata_valid=app_rdata_valid, pH_rdata_end=app_rdata_end, other port 0; combinational, zero latency. Pop on app_rdata_valid & app_rdata_end. Push and pop in same cycle allowed (count unchanged; full FIFO may push when popping). Valid data with FIFO empty: dropped, err set.
- Tag FIFO pointers wrap modulo TAG_DEPTH; count width log2(TAG_DEPTH)+1.

Test Plan:
- Single port 0 write, burst_number=3, app_cmd_rdy after 2 cycles -> app_cmd_en held 2 cycles, p0_cmd_rdy one pulse, 4 beats forwarded, app_wdata_end only on beat 4.
- Both ports request reads every opportunity after reset -> grants 0,1,0,1; returns with end per command route alternately to p0/p1, no cross-delivery.
- 8 reads from p1 with no rdata returned (TAG_DEPTH=8) -> 9th p1 read stalls, p0 write still granted; first rdata_end pops and unblocks p1.
- app_rdata_valid with FIFO empty -> no pN_rdata_valid, err_orphan_rdata=1 sticky until reset.
- init_calib_complete=0 with both pending -> no app_cmd_en; rise -> port 0 granted next cycle.
- rstn low during WDATA beat 2 of 4 -> next cycle all outputs 0, FIFO empty, state IDLE; fresh write completes normally.

Source files
------------

// File: rtl/ddr3_app_arbiter.sv
// Two-port arbiter in front of the Gowin DDR3 controller application interface.
// Whole transactions are granted round-robin; write beats are steered from the
// granted port, and in-order read returns are routed back through a tag FIFO.
module ddr3_app_arbiter #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MASK_W    = 16,
    parameter int unsigned BURST_W   = 6,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               init_calib_complete,

    // Requester port 0
    input  logic               p0_cmd_en,
    input  logic [2:0]         p0_cmd,
    input  logic [ADDR_W-1:0]  p0_addr,
    input  logic [BURST_W-1:0] p0_burst_number,
    output logic               p0_cmd_rdy,
    input  logic               p0_wdata_en,
    input  logic [DATA_W-1:0]  p0_wdata,
    input  logic [MASK_W-1:0]  p0_wdata_mask,
    output logic               p0_wdata_rdy,
    output logic [DATA_W-1:0]  p0_rdata,
    output logic               p0_rdata_valid,
    output logic               p0_rdata_end,

    // Requester port 1
    input  logic               p1_cmd_en,
    input  logic [2:0]         p1_cmd,
    input  logic [ADDR_W-1:0]  p1_addr,
    input  logic [BURST_W-1:0] p1_burst_number,
    output logic               p1_cmd_rdy,
    input  logic               p1_wdata_en,
    input  logic [DATA_W-1:0]  p1_wdata,
    input  logic [MASK_W-1:0]  p1_wdata_mask,
    output logic               p1_wdata_rdy,
    output logic [DATA_W-1:0]  p1_rdata,
    output logic               p1_rdata_valid,
    output logic               p1_rdata_end,

    // Controller application interface
    output logic               app_cmd_en,
    output logic [2:0]         app_cmd,
    output logic [ADDR_W-1:0]  app_addr,
    output logic [BURST_W-1:0] app_burst_number,
    input  logic               app_cmd_rdy,
    output logic               app_wdata_en,
    output logic               app_wdata_end,
    output logic [DATA_W-1:0]  app_wdata,
    output logic [MASK_W-1:0]  app_wdata_mask,
    input  logic               app_wdata_rdy,
    input  logic               app_rdata_valid,
    input  logic               app_rdata_end,
    input  logic [DATA_W-1:0]  app_rdata,

    output logic               err_orphan_rdata
);

    // TAG_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] CmdWrite = 3'b000;
    localparam logic [2:0] CmdRead  = 3'b001;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWdata
    } state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic               gnt_q, gnt_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic               err_q, err_d;

    // Tag FIFO: one entry per outstanding read command, holding the issuing port.
    logic               tag_mem_q [TAG_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic               fifo_full, fifo_empty;
    logic               head_tag;
    logic               push, push_ok, pop;
    logic               set_err, orphan;

    logic               elig0, elig1, pick;
    logic               sel_wdata_en;
    logic [DATA_W-1:0]  sel_wdata;
    logic [MASK_W-1:0]  sel_wdata_mask;
    logic               last_beat;

    assign fifo_full  = (count_q == CntW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_mem_q[rd_ptr_q];

    // A full FIFO can still take a push in a cycle where the head is retired.
    assign push_ok = push & (~fifo_full | pop);
    assign pop     = app_rdata_valid & app_rdata_end & ~fifo_empty;
    assign orphan  = app_rdata_valid & fifo_empty;

    // Reads are only eligible with tag space; writes are always eligible.
    assign elig0 = p0_cmd_en & ((p0_cmd != CmdRead) | ~fifo_full);
    assign elig1 = p1_cmd_en & ((p1_cmd != CmdRead) | ~fifo_full);

    assign sel_wdata_en   = gnt_q ? p1_wdata_en   : p0_wdata_en;
    assign sel_wdata      = gnt_q ? p1_wdata      : p0_wdata;
    assign sel_wdata_mask = gnt_q ? p1_wdata_mask : p0_wdata_mask;
    assign last_beat      = (beat_q == burst_q);

    assign p0_rdata         = app_rdata;
    assign p1_rdata         = app_rdata;
    assign err_orphan_rdata = err_q;

    // Round-robin pick: rr pointer only matters when both ports are eligible.
    always_comb begin
        pick = 1'b0;
        if (elig0 && elig1) begin
            pick = rr_q;
        end else begin
            pick = elig1;
        end
    end

    // Transaction FSM next-state and app-side outputs.
    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        gnt_d            = gnt_q;
        cmd_d            = cmd_q;
        addr_d           = addr_q;
        burst_d          = burst_q;
        beat_d           = beat_q;
        push             = 1'b0;
        set_err          = 1'b0;
        app_cmd_en       = 1'b0;
        app_cmd          = '0;
        app_addr         = '0;
        app_burst_number = '0;
        app_wdata_en     = 1'b0;
        app_wdata_end    = 1'b0;
        app_wdata        = '0;
        app_wdata_mask   = '0;
        p0_cmd_rdy       = 1'b0;
        p1_cmd_rdy       = 1'b0;
        p0_wdata_rdy     = 1'b0;
        p1_wdata_rdy     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_calib_complete && (elig0 || elig1)) begin
                    gnt_d   = pick;
                    rr_d    = ~pick;
                    cmd_d   = pick ? p1_cmd : p0_cmd;
                    addr_d  = pick ? p1_addr : p0_addr;
                    burst_d = pick ? p1_burst_number : p0_burst_number;
                    state_d = StCmd;
                end
            end

            StCmd: begin
                app_cmd_en       = 1'b1;
                app_cmd          = cmd_q;
                app_addr         = addr_q;
                app_burst_number = burst_q;
                if (app_cmd_rdy) begin
                    p0_cmd_rdy = ~gnt_q;
                    p1_cmd_rdy = gnt_q;
                    if (cmd_q == CmdRead) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else if (cmd_q == CmdWrite) begin
                        beat_d  = '0;
                        state_d = StWdata;
                    end else begin
                        // Unknown opcode is still forwarded but flagged.
                        set_err = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            StWdata: begin
                app_wdata_en   = sel_wdata_en;
                app_wdata      = sel_wdata;
                app_wdata_mask = sel_wdata_mask;
                app_wdata_end  = sel_wdata_en & last_beat;
                p0_wdata_rdy   = ~gnt_q & app_wdata_rdy;
                p1_wdata_rdy   = gnt_q & app_wdata_rdy;
                if (sel_wdata_en && app_wdata_rdy) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err_d = err_q | set_err | orphan;

    // Read return routing: head tag steers the controller's read beat.
    always_comb begin
        p0_rdata_valid = 1'b0;
        p1_rdata_valid = 1'b0;
        p0_rdata_end   = 1'b0;
        p1_rdata_end   = 1'b0;
        if (!fifo_empty) begin
            p0_rdata_valid = app_rdata_valid & ~head_tag;
            p1_rdata_valid = app_rdata_valid & head_tag;
            p0_rdata_end   = app_rdata_end & ~head_tag;
            p1_rdata_end   = app_rdata_end & head_tag;
        end
    end

    // FSM and latched command registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Tag storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            tag_mem_q[wr_ptr_q] <= gnt_q;
        end
    end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter: directed stimulus pushes expected
// commands, write beats and read routings; a negedge monitor pops and compares.
module tb_ddr3_app_arbiter;

    localparam int unsigned ADDR_W    = 27;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned MASK_W    = 16;
    localparam int unsigned BURST_W   = 6;
    localparam int unsigned TAG_DEPTH = 8;
    localparam logic [2:0]  CW = 3'b000;
    localparam logic [2:0]  CR = 3'b001;

    logic               clk, rstn, init_calib_complete;
    logic               p0_cmd_en, p1_cmd_en;
    logic [2:0]         p0_cmd, p1_cmd;
    logic [ADDR_W-1:0]  p0_addr, p1_addr;
    logic [BURST_W-1:0] p0_burst_number, p1_burst_number;
    logic               p0_cmd_rdy, p1_cmd_rdy;
    logic               p0_wdata_en, p1_wdata_en;
    logic [DATA_W-1:0]  p0_wdata, p1_wdata;
    logic [MASK_W-1:0]  p0_wdata_mask, p1_wdata_mask;
    logic               p0_wdata_rdy, p1_wdata_rdy;
    logic [DATA_W-1:0]  p0_rdata, p1_rdata;
    logic               p0_rdata_valid, p1_rdata_valid, p0_rdata_end, p1_rdata_end;
    logic               app_cmd_en;
    logic [2:0]         app_cmd;
    logic [ADDR_W-1:0]  app_addr;
    logic [BURST_W-1:0] app_burst_number;
    logic               app_cmd_rdy;
    logic               app_wdata_en, app_wdata_end;
    logic [DATA_W-1:0]  app_wdata;
    logic [MASK_W-1:0]  app_wdata_mask;
    logic               app_wdata_rdy;
    logic               app_rdata_valid, app_rdata_end;
    logic [DATA_W-1:0]  app_rdata;
    logic               err_orphan_rdata;

    ddr3_app_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .init_calib_complete(init_calib_complete),
        .p0_cmd_en(p0_cmd_en), .p0_cmd(p0_cmd), .p0_addr(p0_addr),
        .p0_burst_number(p0_burst_number), .p0_cmd_rdy(p0_cmd_rdy),
        .p0_wdata_en(p0_wdata_en), .p0_wdata(p0_wdata), .p0_wdata_mask(p0_wdata_mask),
        .p0_wdata_rdy(p0_wdata_rdy), .p0_rdata(p0_rdata), .p0_rdata_valid(p0_rdata_valid),
        .p0_rdata_end(p0_rdata_end),
        .p1_cmd_en(p1_cmd_en), .p1_cmd(p1_cmd), .p1_addr(p1_addr),
        .p1_burst_number(p1_burst_number), .p1_cmd_rdy(p1_cmd_rdy),
        .p1_wdata_en(p1_wdata_en), .p1_wdata(p1_wdata), .p1_wdata_mask(p1_wdata_mask),
        .p1_wdata_rdy(p1_wdata_rdy), .p1_rdata(p1_rdata), .p1_rdata_valid(p1_rdata_valid),
        .p1_rdata_end(p1_rdata_end),
        .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_burst_number(app_burst_number), .app_cmd_rdy(app_cmd_rdy),
        .app_wdata_en(app_wdata_en), .app_wdata_end(app_wdata_end), .app_wdata(app_wdata),
        .app_wdata_mask(app_wdata_mask), .app_wdata_rdy(app_wdata_rdy),
        .app_rdata_valid(app_rdata_valid), .app_rdata_end(app_rdata_end),
        .app_rdata(app_rdata), .err_orphan_rdata(err_orphan_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               port;
        logic [2:0]         cmd;
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] burst;
    } cmd_exp_t;

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
        logic              last;
    } wr_exp_t;

    // flags = {p0_valid, p1_valid, p0_end, p1_end}
    typedef struct packed {
        logic [3:0]        flags;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    cmd_exp_t cmd_q[$];
    wr_exp_t  wr_q[$];
    rd_exp_t  rd_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cnt_cmd_en = 0, cnt_rdy0 = 0, cnt_wend = 0, cnt_wbeat = 0;
    int cmd_delay = 0;
    bit wdata_stall = 0;
    bit p1_done;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Controller model: command ready after cmd_delay wait cycles, optional wdata stall.
    initial begin
        int cmd_wait;
        cmd_wait = 0;
        app_cmd_rdy = 1'b0;
        app_wdata_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (app_cmd_en) begin
                app_cmd_rdy = (cmd_wait >= cmd_delay);
                cmd_wait++;
            end else begin
                app_cmd_rdy = 1'b0;
                cmd_wait = 0;
            end
            app_wdata_rdy = wdata_stall ? ~app_wdata_rdy : 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer.
    always @(negedge clk) begin
        cmd_exp_t ce;
        wr_exp_t  we;
        rd_exp_t  re;
        if (rstn) begin
            if (app_cmd_en) cnt_cmd_en++;
            if (p0_cmd_rdy) cnt_rdy0++;
            if (app_wdata_end) cnt_wend++;
            if (app_cmd_en && app_cmd_rdy) begin
                chk("cmd_expected", cmd_q.size() != 0, 1);
                if (cmd_q.size() != 0) begin
                    ce = cmd_q.pop_front();
                    chk("app_cmd", app_cmd, ce.cmd);
                    chk("app_addr", app_addr, ce.addr);
                    chk("app_burst", app_burst_number, ce.burst);
                    chk("cmd_rdy_route", {p1_cmd_rdy, p0_cmd_rdy}, ce.port ? 2'b10 : 2'b01);
                end
            end
            if (app_wdata_en && app_wdata_rdy) begin
                cnt_wbeat++;
                chk("wbeat_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    chk("app_wdata", app_wdata, we.data);
                    chk("app_wdata_mask", app_wdata_mask, we.mask);
                    chk("app_wdata_end", app_wdata_end, we.last);
                    chk("wdata_rdy_route", {p1_wdata_rdy, p0_wdata_rdy},
                        we.port ? 2'b10 : 2'b01);
                end
            end
            if (app_rdata_valid) begin
                chk("rbeat_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    chk("rdata_route",
                        {p0_rdata_valid, p1_rdata_valid, p0_rdata_end, p1_rdata_end}, re.flags);
                    chk("rdata_bcast", {p0_rdata, p1_rdata}, {re.data, re.data});
                end
            end
        end
    end

    task automatic set_req(input int port, input logic en, input logic [2:0] cmd,
                           input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] burst);
        if (port == 0) begin
            p0_cmd_en = en; p0_cmd = cmd; p0_addr = addr; p0_burst_number = burst;
        end else begin
            p1_cmd_en = en; p1_cmd = cmd; p1_addr = addr; p1_burst_number = burst;
        end
    endtask

    task automatic set_wd(input int port, input logic en, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
        if (port == 0) begin
            p0_wdata_en = en; p0_wdata = d; p0_wdata_mask = m;
        end else begin
            p1_wdata_en = en; p1_wdata = d; p1_wdata_mask = m;
        end
    endtask

    // Hold a request until its cmd_rdy pulse, then drop it at the next edge.
    task automatic issue(input int port, input logic [2:0] cmd,
                         input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] burst);
        bit got;
        got = 0;
        set_req(port, 1'b1, cmd, addr, burst);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? p0_cmd_rdy : p1_cmd_rdy;
        end
        chk($sformatf("cmd_accept_p%0d_%0h", port, addr), got, 1);
        @(posedge clk);
        #1;
        set_req(port, 1'b0, 3'b000, '0, '0);
    endtask

    // Write transaction; abort_beat <= burst pulls reset while that beat is offered.
    task automatic write_txn(input int port, input logic [ADDR_W-1:0] addr,
                             input int burst, input logic [DATA_W-1:0] seed,
                             input int abort_beat);
        bit got;
        int n;
        for (int b = 0; b <= burst; b++) begin
            if (b < abort_beat)
                wr_q.push_back({port[0], seed + DATA_W'(b), MASK_W'(b * 3 + 1), b == burst});
        end
        issue(port, CW, addr, BURST_W'(burst));
        for (int b = 0; b <= burst; b++) begin
            set_wd(port, 1'b1, seed + DATA_W'(b), MASK_W'(b * 3 + 1));
            if (b == abort_beat) begin
                rstn = 1'b0;
                tick(1);
                set_wd(port, 1'b0, '0, '0);
                rstn = 1'b1;
                return;
            end
            got = 0;
            n = 0;
            do begin
                @(negedge clk);
                got = (port == 0) ? p0_wdata_rdy : p1_wdata_rdy;
                tick(1);
                n++;
            end while (!got && n < 100);
            chk($sformatf("wbeat_accept_p%0d_%0d", port, b), got, 1);
        end
        set_wd(port, 1'b0, '0, '0);
    endtask

    task automatic rbeat(input logic [DATA_W-1:0] d, input logic e, input logic [3:0] flags);
        rd_q.push_back({flags, d});
        app_rdata_valid = 1'b1;
        app_rdata = d;
        app_rdata_end = e;
        tick(1);
        app_rdata_valid = 1'b0;
        app_rdata_end = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b_rdy0, b_wend, b_wbeat;
        rstn = 1'b0;
        init_calib_complete = 1'b0;
        set_req(0, 1'b0, 3'b000, '0, '0);
        set_req(1, 1'b0, 3'b000, '0, '0);
        set_wd(0, 1'b0, '0, '0);
        set_wd(1, 1'b0, '0, '0);
        app_rdata_valid = 1'b0;
        app_rdata_end = 1'b0;
        app_rdata = '0;
        tick(3);
        @(negedge clk);
        chk("reset_outputs", {app_cmd_en, app_wdata_en, app_wdata_end, p0_cmd_rdy, p1_cmd_rdy,
                              p0_wdata_rdy, p1_wdata_rdy, p0_rdata_valid, p1_rdata_valid,
                              err_orphan_rdata}, 0);
        tick(1);
        rstn = 1'b1;

        // Calibration gate, then both ports reading back-to-back: grants 0,1,0,1.
        cmd_q.push_back({1'b0, CR, 27'h100, 6'd1});
        cmd_q.push_back({1'b1, CR, 27'h200, 6'd1});
        cmd_q.push_back({1'b0, CR, 27'h102, 6'd1});
        cmd_q.push_back({1'b1, CR, 27'h202, 6'd1});
        fork
            begin issue(0, CR, 27'h100, 6'd1); issue(0, CR, 27'h102, 6'd1); end
            begin issue(1, CR, 27'h200, 6'd1); issue(1, CR, 27'h202, 6'd1); end
            begin
                base = cnt_cmd_en;
                tick(6);
                @(negedge clk);
                chk("calib_low_no_cmd", cnt_cmd_en - base, 0);
                tick(1);
                init_calib_complete = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("calib_rise_grant_p0", {app_cmd_en, p0_cmd_rdy, app_addr},
                    {1'b1, 1'b1, 27'h100});
            end
        join
        // Two beats per read, returned in issue order p0,p1,p0,p1.
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 2; b++) begin
                rbeat(DATA_W'(32'h5000 + c * 2 + b), b == 1,
                      (c % 2 == 1) ? {3'b010, b == 1} : {2'b10, b == 1, 1'b0});
            end
        end

        // Single p0 write, burst 3, command ready on the second CMD cycle.
        cmd_delay = 1;
        base = cnt_cmd_en; b_rdy0 = cnt_rdy0; b_wend = cnt_wend; b_wbeat = cnt_wbeat;
        cmd_q.push_back({1'b0, CW, 27'h010, 6'd3});
        write_txn(0, 27'h010, 3, 128'hA0, 99);
        tick(2);
        chk("wr_cmd_en_cycles", cnt_cmd_en - base, 2);
        chk("wr_cmd_rdy_pulses", cnt_rdy0 - b_rdy0, 1);
        chk("wr_end_count", cnt_wend - b_wend, 1);
        chk("wr_beat_count", cnt_wbeat - b_wbeat, 4);
        cmd_delay = 0;

        // Fill the tag FIFO from p1; its 9th read stalls while p0 still writes.
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back({1'b1, CR, 27'h300 + ADDR_W'(i), 6'd0});
            issue(1, CR, 27'h300 + ADDR_W'(i), 6'd0);
        end
        cmd_q.push_back({1'b0, CW, 27'h040, 6'd1});
        cmd_q.push_back({1'b1, CR, 27'h308, 6'd0});
        p1_done = 0;
        fork
            begin issue(1, CR, 27'h308, 6'd0); p1_done = 1; end
        join_none
        write_txn(0, 27'h040, 1, 128'hB0, 99);
        tick(4);
        chk("full_fifo_stalls_p1", p1_done, 0);
        rbeat(128'hC0, 1'b1, 4'b0101);
        for (int i = 0; i < 20 && !p1_done; i++) tick(1);
        chk("pop_unblocks_p1", p1_done, 1);
        for (int i = 0; i < 8; i++) rbeat(128'hD0 + DATA_W'(i), 1'b1, 4'b0101);

        // Orphan read data: nothing routed, sticky error.
        rbeat(128'hEE, 1'b1, 4'b0000);
        @(negedge clk);
        chk("orphan_err_set", err_orphan_rdata, 1);
        tick(3);
        @(negedge clk);
        chk("orphan_err_sticky", err_orphan_rdata, 1);
        tick(1);

        // Reset during beat 2 of a 4-beat write with one read tag outstanding.
        cmd_q.push_back({1'b1, CR, 27'h400, 6'd0});
        issue(1, CR, 27'h400, 6'd0);
        cmd_q.push_back({1'b0, CW, 27'h050, 6'd3});
        write_txn(0, 27'h050, 3, 128'hF0, 1);
        @(negedge clk);
        chk("midburst_reset_outputs",
            {app_cmd_en, app_cmd, app_addr, app_burst_number, app_wdata_en, app_wdata_end,
             app_wdata, app_wdata_mask, p0_cmd_rdy, p1_cmd_rdy, p0_wdata_rdy, p1_wdata_rdy,
             p0_rdata_valid, p1_rdata_valid, p0_rdata_end, p1_rdata_end}, 0);
        chk("midburst_reset_err", err_orphan_rdata, 0);
        tick(1);
        rbeat(128'h77, 1'b1, 4'b0000);
        @(negedge clk);
        chk("reset_emptied_fifo", err_orphan_rdata, 1);
        tick(1);
        wdata_stall = 1;
        cmd_q.push_back({1'b1, CW, 27'h060, 6'd1});
        write_txn(1, 27'h060, 1, 128'h1234, 99);
        wdata_stall = 0;

        // Illegal opcode is forwarded and flagged, and pushes no tag.
        do_reset();
        @(negedge clk);
        chk("reset_clears_err", err_orphan_rdata, 0);
        tick(1);
        cmd_q.push_back({1'b0, 3'b010, 27'h070, 6'd0});
        issue(0, 3'b010, 27'h070, 6'd0);
        @(negedge clk);
        chk("illegal_cmd_err", err_orphan_rdata, 1);
        tick(1);
        cmd_q.push_back({1'b1, CR, 27'h080, 6'd2});
        issue(1, CR, 27'h080, 6'd2);
        rbeat(128'h81, 1'b0, 4'b0100);
        rbeat(128'h82, 1'b0, 4'b0100);
        rbeat(128'h83, 1'b1, 4'b0101);

        tick(3);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
